// File: rtl/sync_fifo_if.sv
// Handshake bundle between a FIFO driver (master) and the FIFO storage (slave).
interface sync_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             w_en;
  logic [WIDTH-1:0] data_in;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and sticky
// overflow/underflow flags.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             full, empty;
  logic             wr_ok, rd_ok;
  logic [AW-1:0]    wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  // Flags come only from registered pointers, so they never glitch.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A write while full is allowed only when a read frees the slot that edge.
  assign rd_ok = bus.r_en && !empty;
  assign wr_ok = bus.w_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_ok};
    data_out_d = rd_ok ? mem_q[rd_addr] : data_out_q;
    ovf_d      = ovf_q | (bus.w_en & ~wr_ok);
    udf_d      = udf_q | (bus.r_en & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[wr_addr] <= bus.data_in;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = wr_ptr_q - rd_ptr_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill/drain, overflow/underflow,
// simultaneous access with wrap, empty corner and reset mid-burst.
module tb_sync_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sync_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive on negedge, let one posedge sample, then settle for checking.
  task automatic cyc(input logic rst, input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    rst_n       = rst;
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;

    // Reset then idle
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_udf", bus.underflow, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("idle_empty", bus.empty, 1);

    // Fill to full
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'(i));
      chk("fill_count", bus.count, i);
      chk("fill_full", bus.full, (i == 8) ? 1 : 0);
      chk("fill_empty", bus.empty, 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'hFF);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_count", bus.count, 8);
    chk("ovf_full", bus.full, 1);

    // Drain to empty
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      chk("drain_dout", bus.data_out, i);
      chk("drain_count", bus.count, 8 - i);
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_udf_clear", bus.underflow, 0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("udf_flag", bus.underflow, 1);
    chk("udf_dout_hold", bus.data_out, 8'h08);
    chk("udf_count", bus.count, 0);
    chk("ovf_sticky", bus.overflow, 1);

    // Clear sticky flags before simultaneous-access checks
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst2_ovf", bus.overflow, 0);
    chk("rst2_udf", bus.underflow, 0);
    chk("rst2_dout", bus.data_out, 0);

    // Simultaneous read/write at count=4 with pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
    chk("sim_pre_count", bus.count, 4);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 8'(8'h10 + i));
      chk("sim_count", bus.count, 4);
      chk("sim_dout", bus.data_out, (i < 4) ? (8'h20 + i) : (8'h10 + i - 4));
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    chk("sim_fill_full", bus.full, 1);
    cyc(1'b1, 1'b1, 1'b1, 8'h40);
    chk("full_rw_count", bus.count, 8);
    chk("full_rw_full", bus.full, 1);
    chk("full_rw_ovf", bus.overflow, 0);
    chk("full_rw_dout", bus.data_out, 8'h16);

    // Drain; contents are 17,18,19,30..33,40
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("drain2_dout", bus.data_out, 8'h40);
    chk("drain2_empty", bus.empty, 1);

    // Empty corner: write accepted, read rejected
    cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    chk("ec_count", bus.count, 1);
    chk("ec_udf", bus.underflow, 1);
    chk("ec_dout_hold", bus.data_out, 8'h40);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("ec_read", bus.data_out, 8'hA5);
    chk("ec_empty", bus.empty, 1);

    // Reset mid-burst
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
    chk("mb_count5", bus.count, 5);
    cyc(1'b0, 1'b1, 1'b0, 8'h99);
    chk("mb_count", bus.count, 0);
    chk("mb_empty", bus.empty, 1);
    chk("mb_udf", bus.underflow, 0);
    chk("mb_ovf", bus.overflow, 0);
    cyc(1'b1, 1'b1, 1'b0, 8'h3C);
    chk("mb_wcount", bus.count, 1);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("mb_read", bus.data_out, 8'h3C);
    chk("mb_empty2", bus.empty, 1);

    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
